// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU command sequencer slice.
//   - UNIT_*  : decode of fun[3:2] into the ALU unit whose flag/result is used
//   - S_*     : sequencer FSM state encodings
//   - FUN_W / cmd_width() : command word layout {fun, a, b}
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int unsigned FUN_W = 4;

    // Command word is {fun, a, b}: fun in the top FUN_W bits, b in the LSBs.
    function automatic int unsigned cmd_width(input int unsigned in_w);
        return FUN_W + 2 * in_w;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous FIFO holding queued ALU commands.
//   Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
//   Ports:
//     clk   in  1      clock, rising edge
//     rst_n in  1      async reset, active-low (empties the FIFO)
//     push  in  1      write din (ignored when full)
//     pop   in  1      drop head entry (ignored when empty)
//     din   in  WIDTH  write data
//     dout  out WIDTH  head entry (valid while !empty)
//     full  out 1      DEPTH entries stored
//     empty out 1      no entries stored
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of 2 gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Upstream command stage for the 16-bit ALU top. Queues {fun,A,B} commands,
//   issues one at a time on registered ALU_A/ALU_B/ALU_FUN, waits for the
//   selected unit's flag (or a timeout) and returns one unified result word
//   over a valid/ready port.
//   Optional feature macro: ALU_SEQ_STATS_EN adds stat_done/stat_tmo counters.
//   Ports:
//     CLK, RST (async, active-low)
//     cmd_valid/cmd_ready, cmd_fun[3:0], cmd_a, cmd_b   command input
//     ALU_A, ALU_B, ALU_FUN                              registered ALU drive
//     Arith_OUT, Carry_Out, logic_OUT, CMP_OUT, SHIFT_OUT unit results
//     Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag        unit result flags
//     res_valid/res_ready, res_data, res_carry, res_fun, res_err  result port
//     stat_done, stat_tmo (ALU_SEQ_STATS_EN only)         saturating counters
//     busy                                                work pending
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned RES_WIDTH  = 2 * IN_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_fun,
    input  logic [IN_WIDTH-1:0]   cmd_a,
    input  logic [IN_WIDTH-1:0]   cmd_b,
    output logic [IN_WIDTH-1:0]   ALU_A,
    output logic [IN_WIDTH-1:0]   ALU_B,
    output logic [3:0]            ALU_FUN,
    input  logic [2*IN_WIDTH-1:0] Arith_OUT,
    input  logic                  Carry_Out,
    input  logic [15:0]           logic_OUT,
    input  logic [3:0]            CMP_OUT,
    input  logic [16:0]           SHIFT_OUT,
    input  logic                  Arith_Flag,
    input  logic                  Logic_Flag,
    input  logic                  CMP_Flag,
    input  logic                  Shift_Flag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RES_WIDTH-1:0]  res_data,
    output logic                  res_carry,
    output logic [3:0]            res_fun,
    output logic                  res_err,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]           stat_done,
    output logic [15:0]           stat_tmo,
`endif
    output logic                  busy
);

    import alu_pkg::*;

    localparam int unsigned     CMD_W    = cmd_width(IN_WIDTH);
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic                 r_live;
    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_tmo_cnt;
    logic [IN_WIDTH-1:0]  r_alu_a;
    logic [IN_WIDTH-1:0]  r_alu_b;
    logic [3:0]           r_alu_fun;
    logic [RES_WIDTH-1:0] r_res_data;
    logic                 r_res_carry;
    logic [3:0]           r_res_fun;
    logic                 r_res_err;

    logic [CMD_W-1:0]     w_cmd_in;
    logic [CMD_W-1:0]     w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_flag;
    logic                 w_tmo;
    logic [RES_WIDTH-1:0] w_unit_res;

    assign w_cmd_in  = {cmd_fun, cmd_a, cmd_b};

    // r_live keeps cmd_ready low while in reset and through the release edge.
    assign cmd_ready = r_live && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_accept  = (r_state == S_HOLD) && res_ready;
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_accept);
    assign w_tmo     = (r_state == S_WAIT) && !w_flag && (r_tmo_cnt == TMO_LAST);

    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign res_valid = (r_state == S_HOLD);
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_fun   = r_res_fun;
    assign res_err   = r_res_err;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_cmd_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Flag and result of the unit selected by the issued command; the other
    // units' flags are not looked at.
    always_comb begin
        w_flag     = 1'b0;
        w_unit_res = '0;
        case (r_alu_fun[3:2])
            UNIT_ARITH: begin
                w_flag     = Arith_Flag;
                w_unit_res = RES_WIDTH'($signed(Arith_OUT));
            end
            UNIT_LOGIC: begin
                w_flag     = Logic_Flag;
                w_unit_res = RES_WIDTH'(logic_OUT);
            end
            UNIT_CMP: begin
                w_flag     = CMP_Flag;
                w_unit_res = RES_WIDTH'(CMP_OUT);
            end
            UNIT_SHIFT: begin
                w_flag     = Shift_Flag;
                w_unit_res = RES_WIDTH'(SHIFT_OUT);
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_live      <= 1'b0;
            r_state     <= S_IDLE;
            r_tmo_cnt   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= '0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_fun   <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;

            // ALU inputs only change on a pop, so they hold between commands.
            if (w_pop) begin
                r_alu_fun <= w_head[CMD_W-1 -: 4];
                r_alu_a   <= w_head[2*IN_WIDTH-1 -: IN_WIDTH];
                r_alu_b   <= w_head[IN_WIDTH-1:0];
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state   <= S_WAIT;
                    r_tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_flag) begin
                        r_res_data  <= w_unit_res;
                        r_res_carry <= (r_alu_fun[3:2] == UNIT_ARITH) && Carry_Out;
                        r_res_fun   <= r_alu_fun;
                        r_res_err   <= 1'b0;
                        r_state     <= S_HOLD;
                    end else if (w_tmo) begin
                        r_res_data  <= '0;
                        r_res_carry <= 1'b0;
                        r_res_fun   <= r_alu_fun;
                        r_res_err   <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_state <= w_empty ? S_IDLE : S_ISSUE;
                    end
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_stat_done;
    logic [15:0] r_stat_tmo;

    assign stat_done = r_stat_done;
    assign stat_tmo  = r_stat_tmo;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stat_done <= '0;
            r_stat_tmo  <= '0;
        end else begin
            if (w_accept && (r_stat_done != '1)) begin
                r_stat_done <= r_stat_done + 16'd1;
            end
            if (w_tmo && (r_stat_tmo != '1)) begin
                r_stat_tmo <= r_stat_tmo + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Directed bench for alu_cmd_sequencer. A registered ALU model drives the
//   unit results/flags from ALU_A/ALU_B/ALU_FUN; expected results are pushed to
//   a scoreboard queue when a command is accepted and a monitor compares them
//   on every result handshake.
//   ALU model: arith = signed A+B (carry = unsigned carry), logic = A^B,
//   cmp = {0, A>B, A<B, A==B} signed, shift = {A,1'b0}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_fun = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [3:0]  ALU_FUN;
    logic [31:0] Arith_OUT = '0;
    logic        Carry_Out = 1'b0;
    logic [15:0] logic_OUT = '0;
    logic [3:0]  CMP_OUT = '0;
    logic [16:0] SHIFT_OUT = '0;
    logic        Arith_Flag = 1'b0;
    logic        Logic_Flag = 1'b0;
    logic        CMP_Flag = 1'b0;
    logic        Shift_Flag = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_carry;
    logic [3:0]  res_fun;
    logic        res_err;
    logic        busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_tmo;
`endif

    // ALU model controls: mute_logic suppresses Logic_Flag, noise raises the
    // flags of all non-selected units.
    logic mute_logic = 1'b0;
    logic noise = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic [3:0]  fun;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    alu_cmd_sequencer #(
        .IN_WIDTH   (16),
        .RES_WIDTH  (32),
        .FIFO_DEPTH (4),
        .TIMEOUT    (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_fun    (cmd_fun),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_FUN    (ALU_FUN),
        .Arith_OUT  (Arith_OUT),
        .Carry_Out  (Carry_Out),
        .logic_OUT  (logic_OUT),
        .CMP_OUT    (CMP_OUT),
        .SHIFT_OUT  (SHIFT_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .Shift_Flag (Shift_Flag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_fun    (res_fun),
        .res_err    (res_err),
`ifdef ALU_SEQ_STATS_EN
        .stat_done  (stat_done),
        .stat_tmo   (stat_tmo),
`endif
        .busy       (busy)
    );

    initial forever #5 CLK = ~CLK;

    // Registered ALU model: samples the sequencer's ALU inputs every edge.
    logic [16:0] m_usum;
    assign m_usum = {1'b0, ALU_A} + {1'b0, ALU_B};

    always @(posedge CLK) begin
        Arith_OUT  <= {{16{ALU_A[15]}}, ALU_A} + {{16{ALU_B[15]}}, ALU_B};
        Carry_Out  <= m_usum[16];
        logic_OUT  <= ALU_A ^ ALU_B;
        CMP_OUT    <= {1'b0, $signed(ALU_A) > $signed(ALU_B),
                       $signed(ALU_A) < $signed(ALU_B), ALU_A == ALU_B};
        SHIFT_OUT  <= {ALU_A, 1'b0};
        Arith_Flag <= (ALU_FUN[3:2] == 2'b00) || noise;
        Logic_Flag <= ((ALU_FUN[3:2] == 2'b01) && !mute_logic) ||
                      ((ALU_FUN[3:2] != 2'b01) && noise);
        CMP_Flag   <= (ALU_FUN[3:2] == 2'b10) || noise;
        Shift_Flag <= (ALU_FUN[3:2] == 2'b11) || noise;
    end

    // Result monitor: compares on each handshake, away from the clock edge.
    initial forever begin
        @(negedge CLK);
        if (RST && res_valid && res_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected: got data=%h fun=%h err=%b, required no result",
                         res_data, res_fun, res_err);
            end else begin
                mon_e = sb.pop_front();
                if ({res_data, res_carry, res_fun, res_err} !==
                    {mon_e.data, mon_e.carry, mon_e.fun, mon_e.err}) begin
                    bad++;
                    $display("FAIL result: got data=%h carry=%b fun=%h err=%b, required data=%h carry=%b fun=%h err=%b",
                             res_data, res_carry, res_fun, res_err,
                             mon_e.data, mon_e.carry, mon_e.fun, mon_e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Offers one command, waiting (bounded) for cmd_ready; queues the expected
    // result on the accepting edge. Called and returns at posedge+1.
    task automatic push_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] d, input logic c, input logic e);
        int unsigned n;
        exp_t x;
        n = 0;
        cmd_valid = 1'b1;
        cmd_fun   = f;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL push_wait: got cmd_ready=0 for %0d cycles, required 1", n);
        end else begin
            @(posedge CLK); #1;
            x.data  = d;
            x.carry = c;
            x.fun   = f;
            x.err   = e;
            sb.push_back(x);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((busy || res_valid) && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (busy || res_valid) begin
            total++;
            bad++;
            $display("FAIL idle_wait: got busy=%b res_valid=%b after %0d cycles, required 0", busy, res_valid, n);
        end
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_alu_side", {26'd0, cmd_ready, busy, ALU_A, ALU_B, ALU_FUN}, 64'd0);
        check("rst_res_side", {25'd0, res_valid, res_data, res_carry, res_fun, res_err}, 64'd0);
`ifdef ALU_SEQ_STATS_EN
        check("rst_stats", {32'd0, stat_done, stat_tmo}, 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;
        check("ready_at_release", {63'd0, cmd_ready}, 64'd0);
        @(posedge CLK); #1;
        check("ready_after_clk", {63'd0, cmd_ready}, 64'd1);

        // Test 1: latency with flag on first WAIT cycle; result 5+3=8
        res_ready = 1'b1;
        push_cmd(4'b0000, 16'd5, 16'd3, 32'd8, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1;
            check("latency_valid", {63'd0, res_valid}, (k == 3) ? 64'd1 : 64'd0);
        end
        wait_idle();

        // Test 2: sign-extended arith, zero-extended shift
        push_cmd(4'b0000, 16'hFFFE, 16'h0000, 32'hFFFF_FFFE, 1'b0, 1'b0);
        push_cmd(4'b1100, 16'h8000, 16'h0000, 32'h0001_0000, 1'b0, 1'b0);
        wait_idle();

        // Test 3/6: fill FIFO with res_ready low, check hold stability and order
        res_ready = 1'b0;
        push_cmd(4'b0101, 16'hF0F0, 16'h0FF0, 32'h0000_FF00, 1'b0, 1'b0);
        push_cmd(4'b0000, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, 1'b0);
        push_cmd(4'b1000, 16'd7,    16'd7,    32'h0000_0001, 1'b0, 1'b0);
        push_cmd(4'b1001, 16'hFFFD, 16'h0002, 32'h0000_0002, 1'b0, 1'b0);
        push_cmd(4'b0001, 16'h0064, 16'hFFCE, 32'h0000_0032, 1'b1, 1'b0);
        check("full_ready", {63'd0, cmd_ready}, 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            check("hold_stable", {27'd0, res_valid, res_fun, res_data}, {27'd0, 1'b1, 4'b0101, 32'h0000_FF00});
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        check("next_issue", {43'd0, ALU_A, ALU_FUN, res_valid}, {43'd0, 16'hFFFF, 4'b0000, 1'b0});
        // Remaining four results at one per 3 cycles: idle after the 12th edge
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK); #1;
            check("throughput_busy", {63'd0, busy}, (k < 12) ? 64'd1 : 64'd0);
        end
        check("sb_after_burst", 64'(sb.size()), 64'd0);

        // Test 4: flag never arrives; other units' flags are noise
        noise = 1'b1;
        mute_logic = 1'b1;
        push_cmd(4'b0100, 16'd1, 16'd2, 32'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK); #1;
            check("timeout_valid", {63'd0, res_valid}, (k == 6) ? 64'd1 : 64'd0);
        end
        @(posedge CLK); #1;
`ifdef ALU_SEQ_STATS_EN
        check("stat_tmo", {48'd0, stat_tmo}, 64'd1);
        check("stat_done", {48'd0, stat_done}, 64'd9);
`endif
        noise = 1'b0;
        mute_logic = 1'b0;
        wait_idle();

        // Test 5: reset while in WAIT with two commands queued
        push_cmd(4'b0000, 16'h1234, 16'h0001, 32'h0000_1235, 1'b0, 1'b0);
        push_cmd(4'b0101, 16'h00FF, 16'h0F0F, 32'h0000_0FF0, 1'b0, 1'b0);
        push_cmd(4'b1000, 16'd3,    16'd3,    32'h0000_0001, 1'b0, 1'b0);
        check("pre_rst_state", {47'd0, busy, ALU_A}, {47'd0, 1'b1, 16'h1234});
        #1;
        RST = 1'b0;
        #1;
        check("midrst_alu_side", {26'd0, cmd_ready, busy, ALU_A, ALU_B, ALU_FUN}, 64'd0);
        check("midrst_res_side", {25'd0, res_valid, res_data, res_carry, res_fun, res_err}, 64'd0);
        sb.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        check("ready_at_rerelease", {63'd0, cmd_ready}, 64'd0);
        @(posedge CLK); #1;
        check("ready_after_reclk", {63'd0, cmd_ready}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            check("post_rst_quiet", {62'd0, busy, res_valid}, 64'd0);
        end

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
